// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester and multiplier signal bundle for mult_arbiter
interface mult_arbiter_if #(
    parameter int WIDTH = 4
);
    logic                 req0;
    logic                 req1;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 done0;
    logic                 done1;
    logic                 err;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 mult_start;
    logic [WIDTH-1:0]     mult_a;
    logic [WIDTH-1:0]     mult_b;
    logic                 mult_fin;
    logic [2*WIDTH-1:0]   mult_result;

    modport master (
        input  req0, req1, a0, b0, a1, b1, mult_fin, mult_result,
        output gnt0, gnt1, done0, done1, err, result, busy, mult_start, mult_a, mult_b
    );

    modport slave (
        output req0, req1, a0, b0, a1, b1, mult_fin, mult_result,
        input  gnt0, gnt1, done0, done1, err, result, busy, mult_start, mult_a, mult_b
    );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sharing of one Booth multiplier between two requesters
module mult_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nx;
    logic               owner;
    logic               last_winner;
    logic               winner;
    logic               tmo;
    logic [CNTW-1:0]    cnt;
    logic [2*WIDTH-1:0] result_q;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic               gnt0_c;
    logic               gnt1_c;
    logic               done0_c;
    logic               done1_c;
    logic               err_c;
    logic               load_c;

    // On a tie the side that did not win last time goes first.
    always_comb begin
        winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = ~last_winner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gnt0_c   = 1'b0;
        gnt1_c   = 1'b0;
        done0_c  = 1'b0;
        done1_c  = 1'b0;
        err_c    = 1'b0;
        load_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                load_c   = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mult_fin || (cnt == CNT_LAST)) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                done0_c  = ~owner;
                done1_c  = owner;
                err_c    = tmo;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (state != S_IDLE) begin
            gnt0_c = ~owner;
            gnt1_c = owner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= 1'b0;
            last_winner <= 1'b1;
            cnt         <= '0;
            tmo         <= 1'b0;
            result_q    <= '0;
            ma          <= '0;
            mb          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner <= winner;
                        ma    <= winner ? bus.a1 : bus.a0;
                        mb    <= winner ? bus.b1 : bus.b0;
                    end
                end
                S_LOAD: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A finish arriving on the last allowed cycle still wins over the timeout.
                    if (bus.mult_fin) begin
                        result_q <= bus.mult_result;
                        tmo      <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        result_q <= '0;
                        tmo      <= 1'b1;
                    end
                end
                S_RESP: last_winner <= owner;
                default: ;
            endcase
        end
    end

    // The multiplier FSM is held cleared for the whole of reset, not just in LOAD.
    assign bus.mult_start = reset | load_c;
    assign bus.mult_a     = ma;
    assign bus.mult_b     = mb;
    assign bus.result     = result_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.gnt0       = gnt0_c;
    assign bus.gnt1       = gnt1_c;
    assign bus.done0      = done0_c;
    assign bus.done1      = done1_c;
    assign bus.err        = err_c;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized self-checking bench for mult_arbiter
module tb_mult_arbiter;
    localparam int W  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;

    mult_arbiter_if #(.WIDTH(W)) bus ();

    mult_arbiter #(.WIDTH(W), .TIMEOUT(TO), .CNTW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit               pend [2];
    logic [W-1:0]     opa  [2];
    logic [W-1:0]     opb  [2];
    int               last;
    int               mlat;
    int               mcnt;
    bit               mrun;
    logic [2*W-1:0]   er;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] pa;
        logic signed [2*W-1:0] pb;
        pa = $signed(a);
        pb = $signed(b);
        return pa * pb;
    endfunction

    task automatic set_side(input int s, input bit r, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[s] = r;
        opa[s]  = a;
        opb[s]  = b;
        if (s == 0) begin
            bus.req0 = r; bus.a0 = a; bus.b0 = b;
        end else begin
            bus.req1 = r; bus.a1 = a; bus.b1 = b;
        end
    endtask

    // Behavioural multiplier: fin rises mlat cycles after start falls.
    initial begin
        bus.mult_fin    = 1'b0;
        bus.mult_result = '0;
        mcnt = 0;
        mrun = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mult_start) begin
                mcnt = 0;
                mrun = 1'b1;
                bus.mult_fin = 1'b0;
            end else if (mrun) begin
                mcnt++;
                if (mcnt == mlat) begin
                    bus.mult_fin    = 1'b1;
                    bus.mult_result = prod(bus.mult_a, bus.mult_b);
                end
            end
        end
    end

    // Entered at a negedge with the DUT idle and requests applied; leaves at the RESP negedge.
    task automatic run_op(input int lat, output logic [2*W-1:0] exp_res);
        int w;
        int n;
        bit eerr;
        w = (pend[0] && pend[1]) ? ((last == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
        eerr = (lat > TO);
        n = eerr ? TO : lat;
        exp_res = eerr ? '0 : prod(opa[w], opb[w]);
        mlat = lat;
        @(posedge clk);
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            check_eq("gnt_owner", (w == 1) ? bus.gnt1 : bus.gnt0, 1);
            check_eq("gnt_other", (w == 1) ? bus.gnt0 : bus.gnt1, 0);
            check_eq("busy", bus.busy, 1);
            check_eq("mult_start", bus.mult_start, (c == 1));
            check_eq("done_owner", (w == 1) ? bus.done1 : bus.done0, (c == n + 2));
            check_eq("done_other", (w == 1) ? bus.done0 : bus.done1, 0);
            check_eq("err", bus.err, (c == n + 2) && eerr);
            check_eq("mult_a", bus.mult_a, opa[w]);
            check_eq("mult_b", bus.mult_b, opb[w]);
            if (c > 1 && c < n + 2 && $urandom_range(0, 2) == 0) begin
                if (w == 1) begin
                    bus.a1 = W'($urandom); bus.b1 = W'($urandom);
                    if ($urandom_range(0, 3) == 0) bus.req1 = 1'b0;
                end else begin
                    bus.a0 = W'($urandom); bus.b0 = W'($urandom);
                    if ($urandom_range(0, 3) == 0) bus.req0 = 1'b0;
                end
            end
        end
        check_eq("result", bus.result, exp_res);
        set_side(w, 1'b0, opa[w], opb[w]);
        last = w;
    endtask

    task automatic idle_check(input logic [2*W-1:0] exp_res);
        @(negedge clk);
        check_eq("idle_busy", bus.busy, 0);
        check_eq("idle_gnt", {bus.gnt1, bus.gnt0}, 0);
        check_eq("idle_done", {bus.done1, bus.done0}, 0);
        check_eq("idle_start", bus.mult_start, 0);
        check_eq("idle_result", bus.result, exp_res);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_side(0, 1'b0, '0, '0);
        set_side(1, 1'b0, '0, '0);
        last = 1;
        @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
        check_eq("rst_done", {bus.done1, bus.done0, bus.err}, 0);
        check_eq("rst_result", bus.result, 0);
        check_eq("rst_operands", {bus.mult_a, bus.mult_b}, 0);
        check_eq("rst_start", bus.mult_start, 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_start", bus.mult_start, 0);
    endtask

    initial begin
        reset = 1'b1;
        mlat  = 1000;
        last  = 1;
        set_side(0, 1'b0, '0, '0);
        set_side(1, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        do_reset();

        set_side(0, 1'b1, 4'd3, 4'd5);
        run_op(4, er);
        check_eq("t1_const", bus.result, 8'h0F);
        idle_check(er);

        do_reset();
        set_side(0, 1'b1, 4'hD, 4'd5);
        set_side(1, 1'b1, 4'd2, 4'd7);
        run_op($urandom_range(1, 5), er);
        check_eq("t2_first", {bus.done0, bus.result}, 9'h1F1);
        idle_check(er);
        run_op($urandom_range(1, 5), er);
        check_eq("t2_second", {bus.done1, bus.result}, 9'h10E);
        idle_check(er);

        set_side(0, 1'b1, W'($urandom), W'($urandom));
        set_side(1, 1'b1, W'($urandom), W'($urandom));
        for (int i = 0; i < 4; i++) begin
            run_op($urandom_range(1, 6), er);
            set_side(last, 1'b1, W'($urandom), W'($urandom));
            idle_check(er);
        end
        set_side(0, 1'b0, '0, '0);
        set_side(1, 1'b0, '0, '0);
        @(negedge clk);

        set_side(1, 1'b1, 4'd5, 4'd5);
        run_op(TO + 5, er);
        idle_check(er);
        set_side(0, 1'b1, 4'd7, 4'h9);
        run_op(TO, er);
        idle_check(er);
        set_side(1, 1'b1, 4'h8, 4'h8);
        run_op(1, er);
        idle_check(er);

        set_side(0, 1'b1, 4'd6, 4'd3);
        mlat = 1000;
        @(posedge clk);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_gnt", {bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 0);
        check_eq("mid_rst_start", bus.mult_start, 1);
        set_side(0, 1'b0, '0, '0);
        last = 1;
        @(negedge clk);
        check_eq("mid_rst_hold", bus.mult_start, 1);
        reset = 1'b0;
        @(negedge clk);
        set_side(0, 1'b1, 4'd6, 4'd3);
        run_op(3, er);
        check_eq("after_rst_const", bus.result, 8'h12);
        idle_check(er);

        for (int i = 0; i < 24; i++) begin
            if (!pend[0] && !pend[1]) begin
                set_side($urandom_range(0, 1), 1'b1, W'($urandom), W'($urandom));
            end
            run_op($urandom_range(1, TO + 2), er);
            for (int s = 0; s < 2; s++) begin
                if (!pend[s] && $urandom_range(0, 1) == 1) begin
                    set_side(s, 1'b1, W'($urandom), W'($urandom));
                end
            end
            idle_check(er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
